signed_seq_divider: RTL and testbench

//  Sequential signed divider: a 2N-bit dividend divided by an N-bit divisor gives an
//  N-bit quotient and an N-bit remainder. It is the inverse datapath of the sequential

---
 rtl/signed_seq_divider_pkg.sv | 23 ++
 rtl/signed_seq_divider_div_step.sv | 41 ++++
 rtl/signed_seq_divider.sv | 224 ++++++++++++++++++++++
 tb/tb_signed_seq_divider.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/signed_seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// signed_seq_divider_pkg
// Shared definitions for the sequential signed divider:
//   - state_e      : FSM state encoding (IDLE=0, LOAD=1, ITER=2, FIX=3, DONE=4)
//   - cnt_width()  : iteration counter width, clog2(2N)+1, so 2N itself fits
// No ports (package).
// -----------------------------------------------------------------------------
package signed_seq_divider_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Counter width for an N-bit divisor: one bit beyond clog2(2N).
    function automatic int cnt_width(input int n);
        cnt_width = $clog2(2 * n) + 1;
    endfunction

endpackage

// File: rtl/signed_seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring shift/subtract step on unsigned magnitudes.
// Ports:
//   i_prem  [N:0]  current partial remainder (before the shift)
//   i_qmsb         bit shifted in from the top of the quotient/shift register
//   i_dabs  [N:0]  divisor magnitude
//   o_prem  [N:0]  partial remainder after shift and conditional subtract
//   o_qbit         quotient bit produced by this step
// -----------------------------------------------------------------------------
import signed_seq_divider_pkg::*;

module div_step #(
    parameter int N = 8
) (
    input  logic [N:0] i_prem,
    input  logic       i_qmsb,
    input  logic [N:0] i_dabs,
    output logic [N:0] o_prem,
    output logic       o_qbit
);

    logic [N+1:0] w_shift;
    logic [N+1:0] w_trial;
    logic         w_ge;

    // Shift the remainder left, try subtracting the divisor, restore if negative.
    always_comb begin
        w_shift = {i_prem, i_qmsb};
        w_trial = w_shift - (N+2)'(i_dabs);
        w_ge    = (w_shift >= (N+2)'(i_dabs));
        if (w_ge) begin
            o_prem = (N+1)'(w_trial);
            o_qbit = 1'b1;
        end else begin
            o_prem = (N+1)'(w_shift);
            o_qbit = 1'b0;
        end
    end

endmodule

// File: rtl/signed_seq_divider.sv
// -----------------------------------------------------------------------------
// signed_seq_divider
// Sequential signed divider: 2N-bit dividend / N-bit divisor -> N-bit quotient
// (truncated toward zero) and N-bit remainder (sign of the dividend). One
// restoring step per clock on magnitudes, sign fix at the end.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      operation request, accepted only in IDLE or DONE
//   dividend   [2N-1:0] signed dividend
//   divisor    [N-1:0]  signed divisor
//   quotient   [N-1:0]  signed quotient
//   remainder  [N-1:0]  signed remainder
//   busy       high while LOAD/ITER/FIX
//   done       high in DONE, held until the next accepted start
//   div_zero   divisor was zero (valid with done)
//   overflow   quotient out of N-bit signed range (valid with done)
// -----------------------------------------------------------------------------
import signed_seq_divider_pkg::*;

module signed_seq_divider #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2*N-1:0]      dividend,
    input  logic [N-1:0]        divisor,
    output logic [N-1:0]        quotient,
    output logic [N-1:0]        remainder,
    output logic                busy,
    output logic                done,
    output logic                div_zero,
    output logic                overflow
);

    localparam int               CW        = cnt_width(N);
    localparam logic [CW-1:0]    LAST_CNT  = CW'(2 * N - 1);
    localparam logic [2*N-1:0]   QPOS_MAX  = (2*N)'((2 ** (N - 1)) - 1);
    localparam logic [2*N-1:0]   QNEG_MAX  = (2*N)'(2 ** (N - 1));

    state_e            r_state;
    state_e            w_state_nxt;

    logic [2*N-1:0]    r_dvd;
    logic [N-1:0]      r_dvs;
    logic [2*N-1:0]    r_qreg;
    logic [N:0]        r_prem;
    logic [N:0]        r_dabs;
    logic              r_dvd_neg;
    logic              r_dvs_neg;
    logic [CW-1:0]     r_cnt;
    logic [N-1:0]      r_quot;
    logic [N-1:0]      r_rem;
    logic              r_busy;
    logic              r_done;
    logic              r_dz;
    logic              r_ovf;

    logic [2*N:0]      w_dvd_ext;
    logic [2*N:0]      w_dvd_abs;
    logic [N:0]        w_dvs_ext;
    logic [N:0]        w_dvs_abs;
    logic              w_dvs_zero;
    logic [N:0]        w_prem_nxt;
    logic              w_qbit;
    logic              w_q_neg;
    logic              w_ovf;
    logic [N-1:0]      w_quot_fix;
    logic [N-1:0]      w_rem_fix;

    div_step #(.N(N)) u_div_step (
        .i_prem (r_prem),
        .i_qmsb (r_qreg[2*N-1]),
        .i_dabs (r_dabs),
        .o_prem (w_prem_nxt),
        .o_qbit (w_qbit)
    );

    // Magnitudes are formed one bit wider so the most negative values stay exact.
    always_comb begin
        w_dvd_ext  = {r_dvd[2*N-1], r_dvd};
        w_dvs_ext  = {r_dvs[N-1], r_dvs};
        w_dvs_zero = (r_dvs == {N{1'b0}});
        if (r_dvd[2*N-1]) begin
            w_dvd_abs = (2*N+1)'(0) - w_dvd_ext;
        end else begin
            w_dvd_abs = w_dvd_ext;
        end
        if (r_dvs[N-1]) begin
            w_dvs_abs = (N+1)'(0) - w_dvs_ext;
        end else begin
            w_dvs_abs = w_dvs_ext;
        end
    end

    // Final sign correction and range check on the unsigned quotient magnitude.
    always_comb begin
        w_q_neg = r_dvd_neg ^ r_dvs_neg;
        if (w_q_neg) begin
            w_ovf      = (r_qreg > QNEG_MAX);
            w_quot_fix = N'(0) - r_qreg[N-1:0];
        end else begin
            w_ovf      = (r_qreg > QPOS_MAX);
            w_quot_fix = r_qreg[N-1:0];
        end
        if (r_dvd_neg) begin
            w_rem_fix = N'(0) - r_prem[N-1:0];
        end else begin
            w_rem_fix = r_prem[N-1:0];
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LOAD: begin
                if (w_dvs_zero) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ITER;
                end
            end
            ST_ITER: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = ST_FIX;
                end else begin
                    w_state_nxt = ST_ITER;
                end
            end
            ST_FIX:  w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: operand capture, iteration, sign fix and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dvd     <= {(2*N){1'b0}};
            r_dvs     <= {N{1'b0}};
            r_qreg    <= {(2*N){1'b0}};
            r_prem    <= {(N+1){1'b0}};
            r_dabs    <= {(N+1){1'b0}};
            r_dvd_neg <= 1'b0;
            r_dvs_neg <= 1'b0;
            r_cnt     <= {CW{1'b0}};
            r_quot    <= {N{1'b0}};
            r_rem     <= {N{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_dvd  <= dividend;
                        r_dvs  <= divisor;
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_dz   <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_dvs_zero) begin
                        r_dz   <= 1'b1;
                        r_quot <= {N{1'b0}};
                        r_rem  <= {N{1'b0}};
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_qreg    <= (2*N)'(w_dvd_abs);
                        r_prem    <= {(N+1){1'b0}};
                        r_dabs    <= w_dvs_abs;
                        r_dvd_neg <= r_dvd[2*N-1];
                        r_dvs_neg <= r_dvs[N-1];
                        r_cnt     <= {CW{1'b0}};
                    end
                end
                ST_ITER: begin
                    r_prem <= w_prem_nxt;
                    r_qreg <= {r_qreg[2*N-2:0], w_qbit};
                    r_cnt  <= r_cnt + CW'(1);
                end
                ST_FIX: begin
                    r_quot <= w_quot_fix;
                    r_rem  <= w_rem_fix;
                    r_ovf  <= w_ovf;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign busy      = r_busy;
    assign done      = r_done;
    assign div_zero  = r_dz;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_signed_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_signed_seq_divider
// Self-checking bench for signed_seq_divider (N=8): directed cases plus random
// operands, compared against integer division in the bench.
// -----------------------------------------------------------------------------
module tb_signed_seq_divider;

    logic               clk;
    logic               reset;
    logic               start;
    logic signed [15:0] dividend;
    logic signed [7:0]  divisor;
    logic [7:0]         quotient;
    logic [7:0]         remainder;
    logic               busy;
    logic               done;
    logic               div_zero;
    logic               overflow;

    int total;
    int bad;

    signed_seq_divider #(.N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Runs one division and checks it against the integer reference.
    // hold: keep start high throughout (back-to-back in DONE).
    // inject: pulse start with other operands mid-ITER (must be ignored).
    task automatic run_op(input logic signed [15:0] a, input logic signed [7:0] b,
                          input bit hold, input bit inject);
        int edges;
        int ia, ib, iq, ir;
        logic [7:0] eq, er;
        logic ed, eo;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        if (!hold) start = 1'b0;
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        check_eq("done_clears_on_start", {31'd0, done}, 32'd0);
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (inject && edges == 5) begin
                dividend = 16'($urandom);
                divisor  = 8'($urandom_range(1, 255));
                start    = 1'b1;
            end
            if (inject && edges == 6) start = 1'b0;
        end
        ia = int'(a);
        ib = int'(b);
        if (ib == 0) begin
            eq = 8'd0; er = 8'd0; ed = 1'b1; eo = 1'b0;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            ed = 1'b0;
            eo = (iq > 127) || (iq < -128);
            eq = iq[7:0];
            er = ir[7:0];
        end
        check_eq("latency", edges, (ib == 0) ? 32'd2 : 32'd19);
        check_eq("quotient", {24'd0, quotient}, {24'd0, eq});
        check_eq("remainder", {24'd0, remainder}, {24'd0, er});
        check_eq("div_zero", {31'd0, div_zero}, {31'd0, ed});
        check_eq("overflow", {31'd0, overflow}, {31'd0, eo});
        check_eq("busy_in_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit seen_done;
        logic signed [15:0] ra;
        logic signed [7:0]  rb;
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 16'sd0;
        divisor  = 8'sd0;
        #2;
        check_eq("rst_quotient", {24'd0, quotient}, 32'd0);
        check_eq("rst_remainder", {24'd0, remainder}, 32'd0);
        check_eq("rst_flags", {28'd0, busy, done, div_zero, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // T1, with done held while start stays low
        run_op(16'sd30, 8'sd6, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_held", {31'd0, done}, 32'd1);
        check_eq("quot_held", {24'd0, quotient}, 32'd5);

        // T2 / T3: sign combinations
        run_op(-16'sd56, 8'sd8, 1'b0, 1'b0);
        run_op(16'sd36, -8'sd9, 1'b0, 1'b0);
        run_op(-16'sd30, -8'sd6, 1'b0, 1'b0);
        run_op(16'sd37, -8'sd5, 1'b0, 1'b0);
        run_op(-16'sd37, 8'sd5, 1'b0, 1'b0);

        // T4: divide by zero, overflow and range boundaries
        run_op(16'sd5, 8'sd0, 1'b0, 1'b0);
        run_op(16'sd16384, 8'sd2, 1'b0, 1'b0);
        run_op(-16'sd256, 8'sd2, 1'b0, 1'b0);
        run_op(16'sd254, 8'sd2, 1'b0, 1'b0);
        run_op(16'sd256, 8'sd2, 1'b0, 1'b0);
        run_op(-16'sd32768, -8'sd128, 1'b0, 1'b0);
        run_op(-16'sd32768, 8'sd1, 1'b0, 1'b0);
        run_op(16'sd127, -8'sd128, 1'b0, 1'b0);

        // T5: start mid-ITER ignored; start held in DONE gives back-to-back ops
        run_op(16'sd1000, 8'sd9, 1'b0, 1'b1);
        run_op(16'sd500, -8'sd7, 1'b1, 1'b0);
        run_op(-16'sd999, 8'sd11, 1'b1, 1'b0);
        run_op(16'sd77, 8'sd0, 1'b1, 1'b0);
        run_op(16'sd123, 8'sd10, 1'b0, 1'b0);

        // T6: reset mid-ITER clears outputs at once and suppresses done
        @(negedge clk);
        dividend = 16'sd900;
        divisor  = 8'sd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("abort_quotient", {24'd0, quotient}, 32'd0);
        check_eq("abort_remainder", {24'd0, remainder}, 32'd0);
        check_eq("abort_flags", {28'd0, busy, done, div_zero, overflow}, 32'd0);
        seen_done = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            seen_done = seen_done | done;
        end
        check_eq("abort_no_done", {31'd0, seen_done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(16'sd900, 8'sd7, 1'b0, 1'b0);

        // Random operands, biased toward in-range quotients half the time
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                rb = 8'sd0;
            end else begin
                rb = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 0) begin
                ra = 16'($urandom);
            end else begin
                ra = 16'(int'($signed(8'($urandom))) * int'(rb)
                         + int'($urandom_range(0, 20)) - 10);
            end
            run_op(ra, rb, 1'b0, ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
